// File: rtl/dat_block_serializer.sv
`timescale 1ns/1ps
// dat_block_serializer
// Serialises a block of parallel words onto the SD DAT lines.
// A frame is a start bit, the data shifted MSB first, a per-lane CRC16 and an end bit.
// It runs in 1-lane (dat[0]) or 4-lane (dat[3:0]) mode.
// A one-word holding register decouples the word buffer from the shifter.
// If that register is empty when the shifter needs its next word, the frame is aborted.
module dat_block_serializer #(
    parameter int WORD_W  = 32,
    parameter int CNT_W   = 12,
    parameter int CRC_LEN = 16
) (
    input  logic              sd_clock,
    input  logic              reset,
    input  logic              start,
    input  logic              wide_bus,
    input  logic [CNT_W-1:0]  block_words,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic [3:0]        dat_out,
    output logic [3:0]        dat_oe,
    output logic              busy,
    output logic              complete,
    output logic              underrun
);

    localparam int BIT_CNT_W = $clog2(WORD_W);
    localparam int CRC_CNT_W = (CRC_LEN > 1) ? $clog2(CRC_LEN) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_W4  = BIT_CNT_W'(WORD_W / 4 - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_W1  = BIT_CNT_W'(WORD_W - 1);
    localparam logic [CRC_CNT_W-1:0] LAST_CRC = CRC_CNT_W'(CRC_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_END   = 3'd4
    } state_t;

    // CRC16 x^16+x^12+x^5+1, one serial bit per step
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[15];
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t              state_r;
    logic                wide_r;
    logic [CNT_W-1:0]    words_r;      // words still to shift, including the current one
    logic [BIT_CNT_W-1:0] bit_cnt_r;   // bit-cycle index inside the current word
    logic [CRC_CNT_W-1:0] crc_cnt_r;
    logic [WORD_W-1:0]   sr_r;         // bits of the current word not yet driven
    logic [WORD_W-1:0]   hold_r;
    logic                hold_full_r;
    logic [3:0][15:0]    crc_r;
    logic [3:0]          dat_out_r;
    logic [3:0]          dat_oe_r;
    logic                busy_r;
    logic                complete_r;
    logic                underrun_r;

    logic                word_ready_s;
    logic                take_s;
    logic                avail_s;
    logic [3:0]          mask_s;
    logic                last_bit_s;
    logic                final_word_s;
    logic                load_s;
    logic                abort_s;
    logic [WORD_W-1:0]   src_s;
    logic [3:0]          data_bits_s;
    logic [WORD_W-1:0]   shifted_s;
    logic [3:0][15:0]    crc_next_s;
    logic [3:0][15:0]    crc_shift_s;
    logic [3:0]          crc_bits_s;

    // Datapath decode: handshake, load points, next data bits and per-lane CRC update
    always_comb begin
        word_ready_s = busy_r & ~hold_full_r;
        take_s       = word_valid & word_ready_s;
        // a word arriving in the same cycle as a load point is passed straight through
        avail_s      = hold_full_r | take_s;
        mask_s       = wide_r ? 4'hF : 4'h1;
        last_bit_s   = wide_r ? (bit_cnt_r == LAST_W4) : (bit_cnt_r == LAST_W1);
        final_word_s = (words_r == CNT_W'(1));
        load_s       = (state_r == ST_START) |
                       ((state_r == ST_DATA) & last_bit_s & ~final_word_s);
        abort_s      = load_s & ~avail_s;
        if (load_s) begin
            src_s = hold_full_r ? hold_r : word_data;
        end else begin
            src_s = sr_r;
        end
        if (wide_r) begin
            data_bits_s = src_s[WORD_W-1 -: 4];
            shifted_s   = {src_s[WORD_W-5:0], 4'h0};
        end else begin
            data_bits_s = {3'b111, src_s[WORD_W-1]};
            shifted_s   = {src_s[WORD_W-2:0], 1'b0};
        end
        crc_next_s  = crc_r;
        crc_shift_s = crc_r;
        crc_bits_s  = 4'hF;
        for (int l = 0; l < 4; l++) begin
            if (mask_s[l]) begin
                crc_next_s[l]  = crc16_step(crc_r[l], wide_r ? src_s[WORD_W-4+l] : src_s[WORD_W-1]);
                crc_shift_s[l] = {crc_r[l][14:0], 1'b0};
                crc_bits_s[l]  = crc_r[l][15];
            end else begin
                crc_next_s[l]  = crc_r[l];
                crc_shift_s[l] = crc_r[l];
                crc_bits_s[l]  = 1'b1;
            end
        end
    end

    // Frame sequencer with registered pad outputs and status pulses
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            wide_r     <= 1'b0;
            words_r    <= '0;
            bit_cnt_r  <= '0;
            crc_cnt_r  <= '0;
            sr_r       <= '0;
            crc_r      <= '0;
            dat_out_r  <= 4'hF;
            dat_oe_r   <= 4'h0;
            busy_r     <= 1'b0;
            complete_r <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            complete_r <= 1'b0;
            underrun_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (block_words != '0)) begin
                        state_r   <= ST_START;
                        wide_r    <= wide_bus;
                        words_r   <= block_words;
                        bit_cnt_r <= '0;
                        crc_cnt_r <= '0;
                        crc_r     <= '0;
                        dat_out_r <= wide_bus ? 4'h0 : 4'hE;
                        dat_oe_r  <= wide_bus ? 4'hF : 4'h1;
                        busy_r    <= 1'b1;
                    end else begin
                        dat_out_r <= 4'hF;
                        dat_oe_r  <= 4'h0;
                        busy_r    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (avail_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= '0;
                        sr_r      <= shifted_s;
                        dat_out_r <= data_bits_s;
                        crc_r     <= crc_next_s;
                    end else begin
                        state_r    <= ST_IDLE;
                        underrun_r <= 1'b1;
                        dat_out_r  <= 4'hF;
                        dat_oe_r   <= 4'h0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (last_bit_s && final_word_s) begin
                        state_r   <= ST_CRC;
                        crc_cnt_r <= '0;
                        dat_out_r <= crc_bits_s;
                        crc_r     <= crc_shift_s;
                    end else if (abort_s) begin
                        state_r    <= ST_IDLE;
                        underrun_r <= 1'b1;
                        dat_out_r  <= 4'hF;
                        dat_oe_r   <= 4'h0;
                        busy_r     <= 1'b0;
                    end else begin
                        if (last_bit_s) begin
                            words_r   <= words_r - CNT_W'(1);
                            bit_cnt_r <= '0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
                        end
                        sr_r      <= shifted_s;
                        dat_out_r <= data_bits_s;
                        crc_r     <= crc_next_s;
                    end
                end
                ST_CRC: begin
                    if (crc_cnt_r == LAST_CRC) begin
                        state_r   <= ST_END;
                        dat_out_r <= 4'hF;
                    end else begin
                        crc_cnt_r <= crc_cnt_r + CRC_CNT_W'(1);
                        dat_out_r <= crc_bits_s;
                        crc_r     <= crc_shift_s;
                    end
                end
                ST_END: begin
                    state_r    <= ST_IDLE;
                    complete_r <= 1'b1;
                    dat_out_r  <= 4'hF;
                    dat_oe_r   <= 4'h0;
                    busy_r     <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    dat_out_r <= 4'hF;
                    dat_oe_r  <= 4'h0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Holding register: filled by the handshake, drained at load points, emptied at frame end
    always_ff @(posedge sd_clock) begin
        if (reset) begin
            hold_r      <= '0;
            hold_full_r <= 1'b0;
        end else if ((state_r == ST_END) || abort_s) begin
            hold_full_r <= 1'b0;
        end else if (load_s) begin
            hold_full_r <= 1'b0;
        end else if (take_s) begin
            hold_r      <= word_data;
            hold_full_r <= 1'b1;
        end else begin
            hold_full_r <= hold_full_r;
        end
    end

    assign word_ready = word_ready_s;
    assign dat_out    = dat_out_r;
    assign dat_oe     = dat_oe_r;
    assign busy       = busy_r;
    assign complete   = complete_r;
    assign underrun   = underrun_r;

endmodule

// File: tb/tb_dat_block_serializer.sv
`timescale 1ns/1ps
// tb_dat_block_serializer
// Directed and randomised frames compared cycle by cycle against a frame-level reference.
// The reference builds each frame from its definition.
// The CRC is computed as the remainder of the lane message times x^16 divided by the generator.
module tb_dat_block_serializer;

    localparam int WORD_W  = 32;
    localparam int CNT_W   = 12;
    localparam int CRC_LEN = 16;

    logic              sd_clock = 1'b0;
    logic              reset;
    logic              start;
    logic              wide_bus;
    logic [CNT_W-1:0]  block_words;
    logic [WORD_W-1:0] word_data;
    logic              word_valid;
    logic              word_ready;
    logic [3:0]        dat_out;
    logic [3:0]        dat_oe;
    logic              busy;
    logic              complete;
    logic              underrun;

    int checks = 0;
    int errors = 0;

    logic [WORD_W-1:0] words [0:4199];
    logic [10:0]       exp_q [$];

    always #5 sd_clock = ~sd_clock;

    dat_block_serializer #(.WORD_W(WORD_W), .CNT_W(CNT_W), .CRC_LEN(CRC_LEN)) dut (
        .sd_clock    (sd_clock),
        .reset       (reset),
        .start       (start),
        .wide_bus    (wide_bus),
        .block_words (block_words),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .dat_out     (dat_out),
        .dat_oe      (dat_oe),
        .busy        (busy),
        .complete    (complete),
        .underrun    (underrun)
    );

    function automatic logic [10:0] ev(input logic [3:0] d, input logic [3:0] o,
                                       input logic b, input logic c, input logic u);
        return {d, o, b, c, u};
    endfunction

    // remainder of M(x)*x^16 mod (x^16+x^12+x^5+1) by long division
    function automatic logic [15:0] crc_ref(input bit m [$]);
        logic [16:0] rem;
        bit b;
        rem = 17'h00000;
        for (int i = 0; i < m.size() + 16; i++) begin
            b   = (i < m.size()) ? m[i] : 1'b0;
            rem = {rem[15:0], b};
            if (rem[16]) rem = rem ^ 17'h11021;
        end
        return rem[15:0];
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // expected per-cycle outputs of one frame, from the START cycle onward
    task automatic build_exp(input bit l4, input int n, input int stall);
        logic [3:0]  mask;
        logic [3:0]  d;
        logic [15:0] crc [4];
        bit          lq [4][$];
        int          cyc;
        int          nw;
        mask = l4 ? 4'hF : 4'h1;
        cyc  = l4 ? WORD_W / 4 : WORD_W;
        nw   = (stall >= 0 && stall < n) ? stall : n;
        exp_q.delete();
        exp_q.push_back(ev(~mask, mask, 1'b1, 1'b0, 1'b0));
        for (int w = 0; w < nw; w++) begin
            for (int c = 0; c < cyc; c++) begin
                if (l4) d = words[w][WORD_W-1-4*c -: 4];
                else    d = {3'b111, words[w][WORD_W-1-c]};
                for (int l = 0; l < 4; l++) if (mask[l]) lq[l].push_back(d[l]);
                exp_q.push_back(ev(d, mask, 1'b1, 1'b0, 1'b0));
            end
        end
        if (nw < n) begin
            exp_q.push_back(ev(4'hF, 4'h0, 1'b0, 1'b0, 1'b1));
            exp_q.push_back(ev(4'hF, 4'h0, 1'b0, 1'b0, 1'b0));
        end else begin
            for (int l = 0; l < 4; l++) crc[l] = crc_ref(lq[l]);
            for (int k = 0; k < CRC_LEN; k++) begin
                d = 4'hF;
                for (int l = 0; l < 4; l++) if (mask[l]) d[l] = (k < 16) ? crc[l][15-k] : 1'b0;
                exp_q.push_back(ev(d, mask, 1'b1, 1'b0, 1'b0));
            end
            exp_q.push_back(ev(4'hF, mask, 1'b1, 1'b0, 1'b0));
            exp_q.push_back(ev(4'hF, 4'h0, 1'b0, 1'b1, 1'b0));
        end
    endtask

    // pat: 0 random, 1 all zeros, 2 all ones, 3 fixed nibble-ramp pair
    task automatic run_frame(input bit l4, input int n, input int pat, input int stall,
                             input int mid_at, input int rst_at, input bit pre,
                             input bit chain, input bit nl4, input int nn);
        int idx;
        for (int i = 0; i < n + 8; i++) begin
            case (pat)
                1:       words[i] = 32'h00000000;
                2:       words[i] = 32'hFFFFFFFF;
                default: words[i] = $urandom;
            endcase
        end
        if (pat == 3) begin
            words[0] = 32'h12345678;
            words[1] = 32'h9ABCDEF0;
        end
        build_exp(l4, n, stall);
        if (!pre) begin
            @(negedge sd_clock);
            start       = 1'b1;
            wide_bus    = l4;
            block_words = CNT_W'(n);
        end
        idx = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge sd_clock);
            start = 1'b0;
            check($sformatf("frame_l4%0d_n%0d_cyc%0d", l4, n, i),
                  {dat_out, dat_oe, busy, complete, underrun, 1'b0}, {exp_q[i], 1'b0});
            if (i == rst_at) begin
                reset      = 1'b1;
                start      = 1'b1;
                word_valid = 1'b1;
                break;
            end
            if (i == mid_at) begin
                start       = 1'b1;
                wide_bus    = ~l4;
                block_words = CNT_W'($urandom_range(1, 5));
            end
            word_valid = (idx != stall);
            word_data  = words[idx];
            if (word_valid && word_ready) idx++;
            if (chain && (i == exp_q.size() - 1)) begin
                start       = 1'b1;
                wide_bus    = nl4;
                block_words = CNT_W'(nn);
            end
        end
        word_valid = 1'b0;
        if (rst_at >= 0) begin
            @(negedge sd_clock);
            check("reset_mid_frame", {dat_out, dat_oe, busy, complete, underrun, word_ready},
                  {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
            reset      = 1'b0;
            start      = 1'b0;
            word_valid = 1'b0;
            @(negedge sd_clock);
            check("idle_after_reset", {dat_out, dat_oe, busy, complete, underrun, word_ready},
                  {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        end
    endtask

    // Directed sequence followed by randomised frames
    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        wide_bus    = 1'b0;
        block_words = '0;
        word_data   = '0;
        word_valid  = 1'b0;
        repeat (3) @(negedge sd_clock);
        check("reset_state", {dat_out, dat_oe, busy, complete, underrun, word_ready},
              {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;

        // 1-lane single zero word, 50-cycle frame
        run_frame(1'b0, 1, 1, -1, -1, -1, 1'b0, 1'b0, 1'b0, 0);
        // 4-lane single all-ones word, 26-cycle frame
        run_frame(1'b1, 1, 2, -1, -1, -1, 1'b0, 1'b0, 1'b0, 0);
        // 4-lane two words back to back
        run_frame(1'b1, 2, 3, -1, -1, -1, 1'b0, 1'b0, 1'b0, 0);
        // second word of a 3-word block withheld
        run_frame(1'b1, 3, 0, 1, -1, -1, 1'b0, 1'b0, 1'b0, 0);
        // first word withheld in 1-lane mode
        run_frame(1'b0, 2, 0, 0, -1, -1, 1'b0, 1'b0, 1'b0, 0);
        // start while busy is ignored
        run_frame(1'b0, 2, 0, -1, 20, -1, 1'b0, 1'b0, 1'b0, 0);

        // start with zero block_words is ignored
        @(negedge sd_clock);
        start       = 1'b1;
        wide_bus    = 1'b1;
        block_words = '0;
        @(negedge sd_clock);
        start = 1'b0;
        check("zero_words_ignored", {dat_out, dat_oe, busy, complete, underrun, word_ready},
              {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge sd_clock);
        check("zero_words_still_idle", {dat_out, dat_oe, busy, complete, underrun, word_ready},
              {4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});

        // reset mid-DATA, then a clean frame
        run_frame(1'b1, 3, 0, -1, -1, 6, 1'b0, 1'b0, 1'b0, 0);
        run_frame(1'b1, 2, 0, -1, -1, -1, 1'b0, 1'b0, 1'b0, 0);

        // start in the complete cycle
        run_frame(1'b1, 1, 0, -1, -1, -1, 1'b0, 1'b1, 1'b0, 2);
        run_frame(1'b0, 2, 0, -1, -1, -1, 1'b1, 1'b0, 1'b0, 0);

        // randomised frames
        for (int r = 0; r < 8; r++) begin
            run_frame($urandom_range(0, 1) == 1, int'($urandom_range(1, 4)), 0, -1, -1, -1,
                      1'b0, 1'b0, 1'b0, 0);
        end

        // largest block: the word counter must not wrap
        run_frame(1'b1, 4095, 0, -1, -1, -1, 1'b0, 1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
